// File: rtl/ser_pkg.sv
// Shared types and the word-length rule for the parallel-to-serial converter.
package ser_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  // A bit-count field of zero stands for a full-width word.
  function automatic int ser_len(input int data_w, input int mod);
    return (mod == 0) ? data_w : mod;
  endfunction

endpackage

// File: rtl/serializer.sv
// Parallel-to-serial converter: sends 1..DATA_W bits MSB-first, one per clock,
// with a per-bit valid and a busy flag that drops on the last bit for gapless chaining.
module serializer
  import ser_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int MOD_W  = $clog2(DATA_W)
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [MOD_W-1:0]  data_mod_i,
  input  logic              data_val_i,
  output logic              ser_data_o,
  output logic              ser_data_val_o,
  output logic              busy_o
);

  localparam int CNT_W = MOD_W + 1;

  ser_state_e        state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_bit;
  logic              busy;
  logic              accept;

  assign last_bit = (cnt_q == CNT_W'(1));
  assign busy     = (state_q == SHIFT) && !last_bit;
  assign accept   = data_val_i && !busy;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          shreg_d = data_i;
          cnt_d   = CNT_W'(ser_len(DATA_W, int'(data_mod_i)));
        end
      end
      SHIFT: begin
        if (last_bit) begin
          // A word taken on the last bit continues the stream with no gap.
          if (accept) begin
            shreg_d = data_i;
            cnt_d   = CNT_W'(ser_len(DATA_W, int'(data_mod_i)));
          end else begin
            state_d = IDLE;
            shreg_d = '0;
            cnt_d   = '0;
          end
        end else begin
          shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        shreg_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  assign ser_data_val_o = (state_q == SHIFT);
  assign ser_data_o     = ser_data_val_o & shreg_q[DATA_W-1];
  assign busy_o         = busy;

endmodule

// File: tb/tb_serializer.sv
// Directed bench for serializer with hand-computed serial streams.
module tb_serializer;
  import ser_pkg::*;

  localparam int DW = 16;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          arst = 1'b0;
  logic [DW-1:0] data = '0;
  logic [MW-1:0] mod = '0;
  logic          val = 1'b0;
  logic          ser_data;
  logic          ser_val;
  logic          busy;

  int n_chk  = 0;
  int n_pass = 0;

  serializer #(.DATA_W(DW), .MOD_W(MW)) dut (
    .clk_i          (clk),
    .arst_i         (arst),
    .data_i         (data),
    .data_mod_i     (mod),
    .data_val_i     (val),
    .ser_data_o     (ser_data),
    .ser_data_val_o (ser_val),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%b exp=%b at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_val"}, ser_val, 1'b0);
    chk({tag, "_dat"}, ser_data, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  // Checks len consecutive valid bits of w, MSB-first; busy is low only on the last bit.
  task automatic expect_bits(input string tag, input logic [DW-1:0] w, input int len);
    for (int k = 0; k < len; k++) begin
      chk({tag, "_val"}, ser_val, 1'b1);
      chk({tag, "_dat"}, ser_data, w[DW-1-k]);
      chk({tag, "_busy"}, busy, k != len - 1);
      tick();
    end
  endtask

  task automatic send(input logic [DW-1:0] w, input logic [MW-1:0] m);
    data = w;
    mod  = m;
    val  = 1'b1;
    tick();
    val  = 1'b0;
  endtask

  logic [3:0] msbs;
  logic [DW-1:0] wa;

  initial begin
    #1 arst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_idle("reset");
    arst = 1'b0;
    tick();
    chk_idle("post_reset");

    // Full-width word
    send(16'hA5C3, 4'd0);
    expect_bits("a5c3", 16'hA5C3, ser_len(DW, 0));
    chk_idle("a5c3_end");

    // Short word, then idle with no stale data
    send(16'hE000, 4'd3);
    expect_bits("e000", 16'hE000, ser_len(DW, 3));
    chk_idle("e000_end");

    // Back-to-back: B presented on A's last bit
    send(16'hFFFF, 4'd0);
    for (int k = 0; k < 16; k++) begin
      chk("b2b_a_val", ser_val, 1'b1);
      chk("b2b_a_dat", ser_data, 1'b1);
      chk("b2b_a_busy", busy, k != 15);
      if (k == 15) begin
        data = 16'h8000;
        mod  = 4'd2;
        val  = 1'b1;
      end
      tick();
      val = 1'b0;
    end
    expect_bits("b2b_b", 16'h8000, ser_len(DW, 2));
    chk_idle("b2b_end");

    // Word offered while busy is dropped
    send(16'h1234, 4'd0);
    wa = 16'h1234;
    for (int k = 0; k < 16; k++) begin
      chk("drop_val", ser_val, 1'b1);
      chk("drop_dat", ser_data, wa[DW-1-k]);
      if (k == 5) begin
        data = 16'h0F0F;
        mod  = 4'd0;
        val  = 1'b1;
      end
      tick();
      val = 1'b0;
    end
    chk_idle("drop_end");
    tick();
    chk_idle("drop_end2");

    // Asynchronous reset mid-transfer at bit 7
    send(16'hFFFF, 4'd0);
    repeat (7) tick();
    chk("arst_pre_dat", ser_data, 1'b1);
    #2 arst = 1'b1;
    #1;
    chk_idle("arst_now");
    tick();
    arst = 1'b0;
    tick();
    chk_idle("arst_rel");
    send(16'h8001, 4'd0);
    expect_bits("after_arst", 16'h8001, 16);
    chk_idle("after_arst_end");

    // Single-bit words streamed every cycle
    msbs = 4'b1011;
    mod  = 4'd1;
    for (int i = 0; i < 4; i++) begin
      data = {msbs[3-i], 15'h7FFF};
      val  = 1'b1;
      tick();
      chk("len1_val", ser_val, 1'b1);
      chk("len1_dat", ser_data, msbs[3-i]);
      chk("len1_busy", busy, 1'b0);
    end
    val = 1'b0;
    tick();
    chk_idle("len1_end");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
